// File: rtl/io_handshake_if.sv
// Decoder / board-I/O handshake bundle for io_handshake.
// master = core + board side, slave = io_handshake.
interface io_handshake_if #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 16
);
  logic              Input;
  logic              Output;
  logic              Halt;
  logic [DATA_W-1:0] out_data;
  logic [SW_W-1:0]   switches;
  logic              enter_btn;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              stall;
  logic [DATA_W-1:0] out_latch;
  logic              out_valid;
  logic              waiting;
  logic              halted;

  modport master (
    output Input, Output, Halt, out_data, switches, enter_btn,
    input  in_data, in_valid, stall, out_latch, out_valid, waiting, halted
  );

  modport slave (
    input  Input, Output, Halt, out_data, switches, enter_btn,
    output in_data, in_valid, stall, out_latch, out_valid, waiting, halted
  );
endinterface

// File: rtl/io_handshake.sv
// Input/Output/Halt peripheral handshake for the single-cycle MIPS core.
// Define IO_SIGN_EXTEND_EN to sign-extend the switches into in_data (default: zero-extend).
module io_handshake #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clock,
  input  logic          reset_n,
  io_handshake_if.slave io
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_PRESS, DELIVER, WAIT_RELEASE, HALTED} state_t;

  state_t            state_q;
  logic              sync1_q, sync2_q;
  logic              db_q, db_d, press;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] in_data_q, out_latch_q, sw_ext;
  logic              in_valid_q, out_valid_q, waiting_q, halted_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= io.enter_btn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // press fires in the cycle the counter completes, so DELIVER follows one edge later
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    press = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        press = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef IO_SIGN_EXTEND_EN
  logic signed [SW_W-1:0] sw_s;
  assign sw_s   = io.switches;
  assign sw_ext = DATA_W'(sw_s);
`else
  assign sw_ext = DATA_W'(io.switches);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_data_q   <= '0;
      out_latch_q <= '0;
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      waiting_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io.Halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (io.Input) begin
            state_q   <= WAIT_PRESS;
            waiting_q <= 1'b1;
          end else if (io.Output) begin
            out_latch_q <= io.out_data;
            out_valid_q <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (press) begin
            in_data_q  <= sw_ext;
            in_valid_q <= 1'b1;
            waiting_q  <= 1'b0;
            state_q    <= DELIVER;
          end
        end
        DELIVER:      state_q <= WAIT_RELEASE;
        WAIT_RELEASE: if (!db_q) state_q <= IDLE;
        HALTED:       state_q <= HALTED;
        default:      state_q <= IDLE;
      endcase
    end
  end

  // gated by reset_n so a decoded Input cannot stall the core while reset is held
  assign io.stall = reset_n & (((state_q == IDLE) & (io.Input | io.Halt))
                             | (state_q == WAIT_PRESS)
                             | ((state_q == WAIT_RELEASE) & io.Input)
                             | (state_q == HALTED));

  assign io.in_data   = in_data_q;
  assign io.in_valid  = in_valid_q;
  assign io.out_latch = out_latch_q;
  assign io.out_valid = out_valid_q;
  assign io.waiting   = waiting_q;
  assign io.halted    = halted_q;
endmodule

// File: tb/tb_io_handshake.sv
// Self-checking bench for io_handshake with DEBOUNCE_CYCLES=4: directed steps plus randomized transactions.
module tb_io_handshake;
  localparam int DW = 32;
  localparam int SW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_latch = '0;

  io_handshake_if #(.DATA_W(DW), .SW_W(SW)) bus ();

  io_handshake #(.DATA_W(DW), .SW_W(SW), .DEBOUNCE_CYCLES(4)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .io      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [15:0] s);
`ifdef IO_SIGN_EXTEND_EN
    return s[15] ? (32'hFFFF0000 | {16'h0, s}) : {16'h0, s};
`else
    return {16'h0, s};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean hold from the current cycle: press is debounced so DELIVER lands 6 cycles later.
  task automatic press_hold(input logic [15:0] sw);
    bus.switches  = sw;
    bus.enter_btn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 7) bus.Input = 1'b0;
      #1;
      chk("in_valid_timing", bus.in_valid, k == 6);
      if (k == 6) begin
        chk("in_data", bus.in_data, ext(sw));
        chk("stall_deliver", bus.stall, 1'b0);
      end else begin
        chk("stall_press", bus.stall, k < 6);
      end
      tick();
    end
  endtask

  // Short pulses (at most 2 samples) that the debouncer must reject.
  task automatic bounce(input logic active, input logic exp_stall);
    int nb;
    int r;
    nb = $urandom_range(0, 3);
    for (int j = 0; j < nb; j++) begin
      for (int ph = 0; ph < 2; ph++) begin
        r = $urandom_range(1, 2);
        for (int c = 0; c < r; c++) begin
          bus.enter_btn = (ph == 0) ? active : ~active;
          #1;
          chk("in_valid_bounce", bus.in_valid, 1'b0);
          chk("stall_bounce", bus.stall, exp_stall);
          tick();
        end
      end
    end
  endtask

  task automatic idle_wait(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      chk("in_valid_idle", bus.in_valid, 1'b0);
      chk("stall_idle", bus.stall, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] sw;
    logic [2:0]  pat;

    bus.Input = 1'b1; bus.Output = 1'b0; bus.Halt = 1'b0;
    bus.out_data = '0; bus.switches = '0; bus.enter_btn = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    #1;
    chk("rst_in_data", bus.in_data, 0);
    chk("rst_in_valid", bus.in_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_out_latch", bus.out_latch, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_waiting", bus.waiting, 0);
    chk("rst_halted", bus.halted, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("stall_after_release", bus.stall, 1);
    chk("waiting_before_edge", bus.waiting, 0);
    tick();
    #1;
    chk("waiting_set", bus.waiting, 1);
    chk("stall_wait_press", bus.stall, 1);
    tick();

    // fixed bounce 1,1,0 then clean hold
    bus.switches = 16'h8005;
    pat = 3'b011;
    for (int j = 0; j < 3; j++) begin
      bus.enter_btn = pat[j];
      #1;
      chk("in_valid_fixed_bounce", bus.in_valid, 0);
      chk("stall_fixed_bounce", bus.stall, 1);
      tick();
    end
    press_hold(16'h8005);

    // held button plus a second Input: no new delivery until release and re-press
    bus.Input = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("held_stall", bus.stall, 1);
      chk("held_in_valid", bus.in_valid, 0);
      tick();
    end
    bus.enter_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("release_stall", bus.stall, 1);
      chk("release_in_valid", bus.in_valid, 0);
      chk("release_waiting", bus.waiting, k >= 8);
      tick();
    end
    press_hold(16'h1234);
    bounce(1'b0, 1'b0);
    bus.enter_btn = 1'b0;
    idle_wait(8);

    // directed Output
    bus.Output = 1'b1; bus.out_data = 32'hDEADBEEF;
    #1;
    chk("output_stall", bus.stall, 0);
    chk("out_valid_before", bus.out_valid, 0);
    tick();
    bus.Output = 1'b0;
    #1;
    chk("out_latch", bus.out_latch, 32'hDEADBEEF);
    chk("out_valid", bus.out_valid, 1);
    chk("output_stall_after", bus.stall, 0);
    tick();
    model_latch = 32'hDEADBEEF;

    // randomized Input / Output transactions
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        bus.Output = 1'b1; bus.out_data = d;
        #1;
        chk("rnd_output_stall", bus.stall, 0);
        tick();
        bus.Output = 1'b0;
        #1;
        chk("rnd_out_latch", bus.out_latch, d);
        tick();
        model_latch = d;
      end else begin
        sw = 16'($urandom);
        bus.Input = 1'b1;
        bus.Output = 1'($urandom_range(0, 1));
        bus.out_data = $urandom;
        #1;
        chk("rnd_input_stall", bus.stall, 1);
        tick();
        bus.Output = 1'b0;
        #1;
        chk("rnd_waiting", bus.waiting, 1);
        chk("rnd_out_latch_kept", bus.out_latch, model_latch);
        tick();
        bounce(1'b1, 1'b1);
        press_hold(sw);
        bounce(1'b0, 1'b0);
        bus.enter_btn = 1'b0;
        idle_wait(8);
      end
    end

    // Halt overlapping Input wins, then the core stays frozen
    bus.Halt = 1'b1; bus.Input = 1'b1;
    #1;
    chk("halt_stall_now", bus.stall, 1);
    tick();
    bus.Halt = 1'b0; bus.Input = 1'b0;
    for (int k = 0; k < 110; k++) begin
      bus.enter_btn = 1'($urandom_range(0, 1));
      #1;
      chk("halted", bus.halted, 1);
      chk("halted_stall", bus.stall, 1);
      chk("halted_in_valid", bus.in_valid, 0);
      tick();
    end
    bus.enter_btn = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", bus.halted, 0);
    chk("halt_rst_stall", bus.stall, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_halt_halted", bus.halted, 0);
    chk("post_halt_stall", bus.stall, 0);
    chk("post_halt_out_latch", bus.out_latch, 0);
    chk("post_halt_out_valid", bus.out_valid, 0);
    tick();

    // reset mid-WAIT_PRESS with a partial debounce in flight
    bus.Input = 1'b1;
    #1;
    chk("mid_stall", bus.stall, 1);
    tick();
    bus.enter_btn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mid_waiting", bus.waiting, 1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_waiting", bus.waiting, 0);
    tick();
    rst_n = 1'b1;
    press_hold(16'hC3A5);
    bus.enter_btn = 1'b0;
    idle_wait(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
